// File: rtl/approx_chk_pkg.sv
// Shared types and width helpers for the approximate-adder sweep checker.
// Used by the interface, the error accumulator and the top.
package approx_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  function automatic int sum_w(input int opw);
    return opw + 1;
  endfunction

  function automatic int vec_w(input int opw);
    return 2 * opw;
  endfunction

endpackage

// File: rtl/approx_adder_sweep_checker_if.sv
// Operand/sum bus between the sweep checker (master) and the adder under
// test (slave).
interface approx_adder_sweep_checker_if
  import approx_chk_pkg::*;
#(
  parameter int OPW = 2
);

  logic [vec_w(OPW)-1:0] dut_in;
  logic [sum_w(OPW)-1:0] dut_out;

  modport master (
    output dut_in,
    input  dut_out
  );

  modport slave (
    input  dut_in,
    output dut_out
  );

endinterface

// File: rtl/approx_err_acc.sv
// Exact-sum compare and error statistics (max, violation count, sum,
// first violating index) for one checked vector per cycle.
module approx_err_acc
  import approx_chk_pkg::*;
#(
  parameter int OPW = 2,
  parameter int ET  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    v,
  input  logic [vec_w(OPW)-1:0]   idx,
  input  logic [OPW-1:0]          a,
  input  logic [OPW-1:0]          b,
  input  logic [sum_w(OPW)-1:0]   approx,
  output logic                    viol,
  output logic [sum_w(OPW)-1:0]   max_err,
  output logic [2*OPW:0]          viol_cnt,
  output logic [3*OPW:0]          err_sum,
  output logic [vec_w(OPW)-1:0]   first_viol_idx
);

  localparam int SW = sum_w(OPW);
  localparam int EW = 3 * OPW + 1;
  localparam int CW = 2 * OPW + 1;

  logic [SW-1:0] exact;
  logic [SW-1:0] err;
  logic          over;

  always_comb begin
    exact = SW'(a) + SW'(b);
    err   = (approx >= exact) ? approx - exact
                              : exact - approx;
    over  = int'(err) > ET;
    viol  = v && over;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max_err        <= '0;
      viol_cnt       <= '0;
      err_sum        <= '0;
      first_viol_idx <= '1;
    end else if (v) begin
      err_sum <= err_sum + EW'(err);
      if (err > max_err)
        max_err <= err;
      if (over) begin
        viol_cnt <= viol_cnt + CW'(1);
        // only the earliest violation is recorded
        if (viol_cnt == '0)
          first_viol_idx <= idx;
      end
    end
  end

endmodule

// File: rtl/approx_adder_sweep_checker.sv
// Exhaustive operand sweep of an approximate adder with error statistics.
// Define ERR_EARLY_STOP_EN to stop issuing vectors at the first violation.
module approx_adder_sweep_checker
  import approx_chk_pkg::*;
#(
  parameter int OPW = 2,
  parameter int ET  = 1,
  parameter int LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  approx_adder_sweep_checker_if.master dut,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [sum_w(OPW)-1:0] max_err,
  output logic [2*OPW:0]        viol_cnt,
  output logic [3*OPW:0]        err_sum,
  output logic [vec_w(OPW)-1:0] first_viol_idx
);

  localparam int VW = vec_w(OPW);

`ifdef ERR_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  state_t         state;
  state_t         nxt;
  logic [VW-1:0]  idx;
  logic           issue;
  logic           clr;
  logic           viol;
  logic           pipe_empty;
  logic           pv;
  logic [OPW-1:0] pa;
  logic [OPW-1:0] pb;

  assign dut.dut_in = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nxt;
      if (clr)
        idx <= '0;
      else if (issue)
        idx <= idx + VW'(1);
    end
  end

  always_comb begin
    nxt   = state;
    issue = 1'b0;
    clr   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          nxt = SWEEP;
          clr = 1'b1;
        end
      end
      SWEEP: begin
        issue = 1'b1;
        if (&idx || (EARLY_STOP && viol))
          nxt = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty)
          nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  // (valid, a, b) travel alongside the adder's own latency
  if (LAT == 0) begin : g_comb
    assign pv         = issue;
    assign pa         = idx[OPW-1:0];
    assign pb         = idx[VW-1:OPW];
    assign pipe_empty = 1'b1;
  end else begin : g_pipe
    logic [LAT-1:0] vq;
    logic [OPW-1:0] aq [LAT];
    logic [OPW-1:0] bq [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        vq <= '0;
        for (int i = 0; i < LAT; i++) begin
          aq[i] <= '0;
          bq[i] <= '0;
        end
      end else begin
        vq[0] <= issue;
        aq[0] <= idx[OPW-1:0];
        bq[0] <= idx[VW-1:OPW];
        for (int i = 1; i < LAT; i++) begin
          vq[i] <= vq[i-1];
          aq[i] <= aq[i-1];
          bq[i] <= bq[i-1];
        end
      end
    end

    assign pv         = vq[LAT-1];
    assign pa         = aq[LAT-1];
    assign pb         = bq[LAT-1];
    assign pipe_empty = ~|vq;
  end

  approx_err_acc #(
    .OPW (OPW),
    .ET  (ET)
  ) u_acc (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .v              (pv),
    .idx            ({pb, pa}),
    .a              (pa),
    .b              (pb),
    .approx         (dut.dut_out),
    .viol           (viol),
    .max_err        (max_err),
    .viol_cnt       (viol_cnt),
    .err_sum        (err_sum),
    .first_viol_idx (first_viol_idx)
  );

  assign busy = (state == SWEEP) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (viol_cnt == '0);

endmodule
